// File: rtl/fp_pkg.sv
// Shared floating-point package for the FP unit (multiplier and divider).
// Contents:
//   FP_BIAS, EXP_W, FRAC_W, EXP_MAX  IEEE-754 single-precision field constants
//   MUL_ITERS                        mantissa width including hidden bit
//   QNAN                             canonical quiet NaN emitted for invalid ops
//   fp_state_e                       IDLE / MUL / NORM sequencing states
//   fp_class_t, fp_classify()        operand classification from exp/frac fields
package fp_pkg;

    localparam int          FP_BIAS   = 127;
    localparam int          EXP_W     = 8;
    localparam int          FRAC_W    = 23;
    localparam int          MUL_ITERS = 24;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } fp_state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals are flushed, so any operand with a zero exponent counts as zero.
    function automatic fp_class_t fp_classify(input logic [EXP_W-1:0]  e_fld,
                                              input logic [FRAC_W-1:0] f_fld);
        fp_class_t c;
        c.is_zero = (e_fld == '0);
        c.is_inf  = (e_fld == EXP_MAX) && (f_fld == '0);
        c.is_nan  = (e_fld == EXP_MAX) && (f_fld != '0);
        return c;
    endfunction

endpackage

// File: rtl/mant_shift_add.sv
// Iterative shift-add mantissa multiplier, one partial product per step.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   load            initialise P=0, D=mcand, M=mplier, count=0
//   step            one iteration: add D into P when M[0], shift D left, M right
//   mcand, mplier   N-bit mantissas including hidden bit
//   product_hi      product bits [2N-1:N-1]; only these feed normalisation
//   last            high while the final (N-th) step is being applied
module mant_shift_add #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] mcand,
    input  logic [N-1:0] mplier,
    output logic [N:0]   product_hi,
    output logic         last
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] p_q;
    logic [2*N-1:0] d_q;
    logic [N-1:0]   m_q;
    logic [CW-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q   <= '0;
            d_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            p_q   <= '0;
            d_q   <= {{N{1'b0}}, mcand};
            m_q   <= mplier;
            cnt_q <= '0;
        end else if (step) begin
            if (m_q[0]) begin
                p_q <= p_q + d_q;
            end
            d_q   <= d_q << 1;
            m_q   <= m_q >> 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign product_hi = p_q[2*N-1:N-1];
    assign last       = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier with fixed latency.
// Handshake: start is a one-cycle request sampled only in IDLE; busy is high
// from the cycle after acceptance until the result cycle; done pulses for one
// cycle with Out valid, and Out holds until the next result or reset. Starts
// while busy are dropped, never queued.
// Ports:
//   int_clk  clock, all state on posedge
//   reset    synchronous active-high reset, aborts any operation in flight
//   start    request, A/B captured when accepted
//   A, B     IEEE-754 single operands
//   busy     operation in progress
//   done     one-cycle result strobe
//   Out      truncated product
module fp_multiplier #(
    parameter int          MUL_ITERS = fp_pkg::MUL_ITERS,
    parameter logic [31:0] QNAN      = fp_pkg::QNAN
) (
    input  logic        int_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);

    import fp_pkg::*;

    fp_state_e state_q, state_d;

    logic              load, step, last;
    logic [MUL_ITERS:0] p_hi;

    logic              sign_q;
    logic [EXP_W-1:0]  a_exp_q, b_exp_q;
    logic [FRAC_W-1:0] a_frac_q, b_frac_q;
    logic              busy_q, done_q;
    logic [31:0]       out_q;

    fp_class_t         a_cls, b_cls;
    logic [9:0]        e_sum;
    logic [FRAC_W-1:0] frac;
    logic              e_ovf, e_unf;
    logic [31:0]       result;

    mant_shift_add #(.N(MUL_ITERS)) u_mant (
        .clk        (int_clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .mcand      ({1'b1, B[FRAC_W-1:0]}),
        .mplier     ({1'b1, A[FRAC_W-1:0]}),
        .product_hi (p_hi),
        .last       (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (last) state_d = NORM;
            end
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Exponent in 10-bit two's complement: bit 9 flags underflow below zero,
    // values of 255 and above (up to 384) flag overflow.
    always_comb begin
        a_cls  = fp_classify(a_exp_q, a_frac_q);
        b_cls  = fp_classify(b_exp_q, b_frac_q);
        e_sum  = 10'(a_exp_q) + 10'(b_exp_q) - 10'(FP_BIAS) + 10'(p_hi[MUL_ITERS]);
        e_ovf  = !e_sum[9] && (e_sum[8:0] >= 9'd255);
        e_unf  = e_sum[9] || (e_sum == 10'd0);
        // A set top bit means the product is in [2,4): take the fraction one bit higher.
        frac   = p_hi[MUL_ITERS] ? p_hi[MUL_ITERS-1:1] : p_hi[MUL_ITERS-2:0];
        result = {sign_q, e_sum[7:0], frac};
        if (a_cls.is_nan || b_cls.is_nan ||
            (a_cls.is_inf && b_cls.is_zero) || (b_cls.is_inf && a_cls.is_zero)) begin
            result = QNAN;
        end else if (a_cls.is_inf || b_cls.is_inf) begin
            result = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (a_cls.is_zero || b_cls.is_zero) begin
            result = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
        end else if (e_ovf) begin
            result = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (e_unf) begin
            result = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
        end
    end

    always_ff @(posedge int_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            a_exp_q  <= '0;
            b_exp_q  <= '0;
            a_frac_q <= '0;
            b_frac_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (load) begin
                sign_q   <= A[31] ^ B[31];
                a_exp_q  <= A[30:23];
                b_exp_q  <= B[30:23];
                a_frac_q <= A[FRAC_W-1:0];
                b_frac_q <= B[FRAC_W-1:0];
                busy_q   <= 1'b1;
            end
            if (state_q == NORM) begin
                out_q  <= result;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Out  = out_q;

endmodule
